// File: rtl/cbus_rr_arbiter_if.sv
// Bundles the upstream request/response vectors, downstream cbus and status of the cbus arbiter.
// Request (151b): {valid, is_write, size[2:0], addr[63:0], strobe[7:0], data[63:0], len[7:0], burst[1:0]}
// Response (66b): {ready, last, data[63:0]}
interface cbus_rr_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  localparam int REQ_W  = 151;
  localparam int RESP_W = 66;

  logic [NUM_PORTS*REQ_W-1:0]  ireqs;
  logic [NUM_PORTS*RESP_W-1:0] iresps;
  logic [REQ_W-1:0]            oreq;
  logic [RESP_W-1:0]           oresp;
  logic [NUM_PORTS-1:0]        grant;
  logic                        len_err;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq,
    output grant,
    output len_err
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq,
    input  grant,
    input  len_err
  );
endinterface

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 burst arbiter merging cbus masters onto one downstream cbus; one whole burst per grant.
// state | meaning
// IDLE  | no owner, outputs quiet, arbitrating among valid requests
// BUSY  | sel owns the downstream bus until ready&&last or its valid drops
module cbus_rr_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic               clk,
  input logic               resetn,
  cbus_rr_arbiter_if.slave  bus
);
  localparam int IDX_W   = $clog2(NUM_PORTS);
  localparam int REQ_W   = 151;
  localparam int RESP_W  = 66;
  localparam int VALID_B = 150;
  localparam int LEN_LSB = 2;
  localparam int RDY_B   = 65;
  localparam int LAST_B  = 64;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic               len_err_q, len_err_d;

  logic [NUM_PORTS-1:0] req_valid;
  logic [IDX_W-1:0]     win_idx;
  logic                 any_valid;
  logic [REQ_W-1:0]     cur_req;
  logic [IDX_W-1:0]     sel_inc;
  logic [8:0]           beats_done;
  logic [8:0]           len_plus1;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_valid[i] = bus.ireqs[i*REQ_W + VALID_B];
    end
  end

  // Round-robin scans upward from rr_ptr with wrap; fixed priority scans from port 0.
  always_comb begin
    int idx;
    win_idx   = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = FIXED_PRIO ? k : int'(rr_ptr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    cur_req    = bus.ireqs[int'(sel_q)*REQ_W +: REQ_W];
    sel_inc    = (sel_q == IDX_W'(NUM_PORTS - 1)) ? '0 : sel_q + 1'b1;
    beats_done = {1'b0, beat_cnt_q} + 9'd1;
    len_plus1  = {1'b0, cur_req[LEN_LSB +: 8]} + 9'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = BUSY;
          sel_d      = win_idx;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        // A master dropping valid mid-burst aborts it without advancing fairness.
        if (!cur_req[VALID_B]) begin
          state_d   = IDLE;
          len_err_d = 1'b1;
        end else if (bus.oresp[RDY_B]) begin
          beat_cnt_d = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
          if (bus.oresp[LAST_B]) begin
            state_d  = IDLE;
            rr_ptr_d = sel_inc;
            if (beats_done != len_plus1) len_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.oreq    = '0;
    bus.iresps  = '0;
    bus.grant   = '0;
    bus.len_err = len_err_q;
    if (state_q == BUSY) begin
      bus.oreq                                  = cur_req;
      bus.iresps[int'(sel_q)*RESP_W +: RESP_W]  = bus.oresp;
      bus.grant[sel_q]                          = 1'b1;
    end
  end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench: 3-port round-robin arbiter driven from a per-cycle vector table,
// plus hand sequences for abort, async reset and a 2-port fixed-priority instance.
module tb_cbus_rr_arbiter;
  localparam int REQ_W  = 151;
  localparam int RESP_W = 66;

  logic clk;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   beat_seq = 0;
  logic [RESP_W-1:0] resp_a;
  logic [RESP_W-1:0] resp_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cbus_rr_arbiter_if #(.NUM_PORTS(3)) bus_a ();
  cbus_rr_arbiter_if #(.NUM_PORTS(2)) bus_b ();

  cbus_rr_arbiter #(.NUM_PORTS(3), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a.slave)
  );
  cbus_rr_arbiter #(.NUM_PORTS(2), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b.slave)
  );

  typedef struct {
    logic [2:0] vmask;
    logic [7:0] len;
    logic       rdy;
    logic       lst;
    logic [2:0] exp_grant;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [REQ_W-1:0] make_req(input int p, input logic v, input logic [7:0] len);
    logic [REQ_W-1:0] r;
    r            = '0;
    r[150]       = v;
    r[149]       = p[0];
    r[148:146]   = 3'd3;
    r[145:82]    = 64'h8000_0000_0000_0000 + 64'(p) * 64'h40;
    r[81:74]     = 8'hFF;
    r[73:10]     = 64'hA5A5_0000_0000_0000 + 64'(p);
    r[9:2]       = len;
    r[1:0]       = 2'b01;
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] vm, input logic [7:0] len, input logic rdy, input logic lst);
    for (int p = 0; p < 3; p++) bus_a.ireqs[p*REQ_W +: REQ_W] = make_req(p, vm[p], len);
    beat_seq++;
    resp_a = {rdy, lst, 64'hC0DE_0000_0000_0000 + 64'(beat_seq)};
    bus_a.oresp = resp_a;
  endtask

  task automatic drive_b(input logic [1:0] vm, input logic [7:0] len, input logic rdy, input logic lst);
    for (int p = 0; p < 2; p++) bus_b.ireqs[p*REQ_W +: REQ_W] = make_req(p, vm[p], len);
    beat_seq++;
    resp_b = {rdy, lst, 64'hB0B0_0000_0000_0000 + 64'(beat_seq)};
    bus_b.oresp = resp_b;
  endtask

  task automatic step_a(input logic [2:0] vm, input logic [7:0] len, input logic rdy, input logic lst);
    @(posedge clk);
    #1;
    drive_a(vm, len, rdy, lst);
  endtask

  task automatic step_b(input logic [1:0] vm, input logic [7:0] len, input logic rdy, input logic lst);
    @(posedge clk);
    #1;
    drive_b(vm, len, rdy, lst);
  endtask

  task automatic add_vec(input logic [2:0] vm, input logic [7:0] len, input logic rdy, input logic lst,
                         input logic [2:0] eg, input logic ee);
    vec_t v;
    v.vmask = vm; v.len = len; v.rdy = rdy; v.lst = lst; v.exp_grant = eg; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic check_a(input string tag, input logic [2:0] vm, input logic [7:0] len,
                         input logic [2:0] eg, input logic ee);
    logic [REQ_W-1:0]    e_oreq;
    logic [3*RESP_W-1:0] e_iresps;
    e_oreq   = '0;
    e_iresps = '0;
    for (int p = 0; p < 3; p++) begin
      if (eg[p]) begin
        e_oreq = make_req(p, vm[p], len);
        e_iresps[p*RESP_W +: RESP_W] = resp_a;
      end
    end
    check({tag, " grant"},   256'(bus_a.grant),   256'(eg));
    check({tag, " len_err"}, 256'(bus_a.len_err), 256'(ee));
    check({tag, " oreq"},    256'(bus_a.oreq),    256'(e_oreq));
    check({tag, " iresps"},  256'(bus_a.iresps),  256'(e_iresps));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with port 0 requesting: everything must stay quiet.
    resetn = 1'b0;
    drive_a(3'b001, 8'd0, 1'b0, 1'b0);
    drive_b(2'b01, 8'd0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst%0d a_oreq", c), 256'(bus_a.oreq), 256'(0));
      check($sformatf("rst%0d a_grant", c), 256'(bus_a.grant), 256'(0));
      check($sformatf("rst%0d a_len_err", c), 256'(bus_a.len_err), 256'(0));
      check($sformatf("rst%0d b_grant", c), 256'(bus_b.grant), 256'(0));
    end
    @(posedge clk);
    #1;
    drive_a(3'b000, 8'd0, 1'b0, 1'b0);
    drive_b(2'b00, 8'd0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst a_grant", 256'(bus_a.grant), 256'(0));

    //       vmask   len   rdy   lst   grant   err
    add_vec(3'b010, 8'd3, 1'b0, 1'b0, 3'b000, 1'b0); // single port 1, 4-beat burst
    add_vec(3'b010, 8'd3, 1'b1, 1'b0, 3'b010, 1'b0);
    add_vec(3'b010, 8'd3, 1'b1, 1'b0, 3'b010, 1'b0);
    add_vec(3'b010, 8'd3, 1'b1, 1'b0, 3'b010, 1'b0);
    add_vec(3'b010, 8'd3, 1'b1, 1'b1, 3'b010, 1'b0);
    add_vec(3'b000, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    add_vec(3'b011, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0); // RR fairness 0,1,0,1
    add_vec(3'b011, 8'd0, 1'b1, 1'b1, 3'b001, 1'b0);
    add_vec(3'b011, 8'd0, 1'b1, 1'b1, 3'b000, 1'b0); // ready while IDLE ignored
    add_vec(3'b011, 8'd0, 1'b1, 1'b1, 3'b010, 1'b0);
    add_vec(3'b011, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    add_vec(3'b011, 8'd0, 1'b1, 1'b1, 3'b001, 1'b0);
    add_vec(3'b011, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    add_vec(3'b011, 8'd0, 1'b1, 1'b1, 3'b010, 1'b0);
    add_vec(3'b101, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0); // wrap: rr_ptr=2
    add_vec(3'b101, 8'd0, 1'b1, 1'b1, 3'b100, 1'b0);
    add_vec(3'b101, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    add_vec(3'b101, 8'd0, 1'b1, 1'b1, 3'b001, 1'b0);
    add_vec(3'b101, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    add_vec(3'b101, 8'd0, 1'b1, 1'b1, 3'b100, 1'b0);
    add_vec(3'b000, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    add_vec(3'b001, 8'd3, 1'b0, 1'b0, 3'b000, 1'b0); // short burst: last on beat 2
    add_vec(3'b001, 8'd3, 1'b1, 1'b0, 3'b001, 1'b0);
    add_vec(3'b001, 8'd3, 1'b1, 1'b1, 3'b001, 1'b0);
    add_vec(3'b000, 8'd3, 1'b0, 1'b0, 3'b000, 1'b1);
    add_vec(3'b001, 8'd0, 1'b0, 1'b0, 3'b000, 1'b1); // good burst keeps sticky error
    add_vec(3'b001, 8'd0, 1'b1, 1'b1, 3'b001, 1'b1);
    add_vec(3'b000, 8'd0, 1'b0, 1'b0, 3'b000, 1'b1);
    add_vec(3'b010, 8'd3, 1'b0, 1'b0, 3'b000, 1'b1); // abort: port 1 drops valid
    add_vec(3'b010, 8'd3, 1'b1, 1'b0, 3'b010, 1'b1);
    add_vec(3'b000, 8'd3, 1'b0, 1'b0, 3'b010, 1'b1);
    add_vec(3'b011, 8'd0, 1'b0, 1'b0, 3'b000, 1'b1); // rr_ptr still 1 -> port 1 wins
    add_vec(3'b011, 8'd0, 1'b1, 1'b1, 3'b010, 1'b1);
    add_vec(3'b000, 8'd0, 1'b0, 1'b0, 3'b000, 1'b1);

    foreach (vecs[i]) begin
      step_a(vecs[i].vmask, vecs[i].len, vecs[i].rdy, vecs[i].lst);
      @(negedge clk);
      check_a($sformatf("vec%0d", i), vecs[i].vmask, vecs[i].len, vecs[i].exp_grant, vecs[i].exp_err);
    end

    // Synchronous-looking reset pulse clears the sticky error.
    @(posedge clk);
    #1;
    resetn = 1'b0;
    drive_a(3'b000, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst2 a_len_err", 256'(bus_a.len_err), 256'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Abort on a clean error flag, then confirm rr_ptr did not advance.
    step_a(3'b001, 8'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("abort idle grant", 256'(bus_a.grant), 256'(0));
    step_a(3'b001, 8'd3, 1'b1, 1'b0);
    @(negedge clk);
    check("abort busy grant", 256'(bus_a.grant), 256'(3'b001));
    step_a(3'b000, 8'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("abort drop grant", 256'(bus_a.grant), 256'(3'b001));
    check("abort drop ovalid", 256'(bus_a.oreq[150]), 256'(0));
    check("abort drop len_err", 256'(bus_a.len_err), 256'(0));
    step_a(3'b000, 8'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("abort after grant", 256'(bus_a.grant), 256'(0));
    check("abort after len_err", 256'(bus_a.len_err), 256'(1));
    step_a(3'b011, 8'd0, 1'b0, 1'b0);
    step_a(3'b011, 8'd0, 1'b1, 1'b1);
    @(negedge clk);
    check("abort rr_ptr grant", 256'(bus_a.grant), 256'(3'b001));

    // Async reset mid-burst: outputs drop without waiting for a clock edge.
    step_a(3'b100, 8'd3, 1'b0, 1'b0);
    step_a(3'b100, 8'd3, 1'b1, 1'b0);
    @(negedge clk);
    check("async pre grant", 256'(bus_a.grant), 256'(3'b100));
    #2;
    resetn = 1'b0;
    #1;
    check("async grant", 256'(bus_a.grant), 256'(0));
    check("async oreq", 256'(bus_a.oreq), 256'(0));
    check("async iresps", 256'(bus_a.iresps), 256'(0));
    check("async len_err", 256'(bus_a.len_err), 256'(0));
    @(posedge clk);
    #1;
    drive_a(3'b000, 8'd0, 1'b0, 1'b0);
    drive_b(2'b00, 8'd0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("async post grant", 256'(bus_a.grant), 256'(0));

    // Fixed priority: both ports always requesting, port 0 always wins.
    for (int c = 0; c < 8; c++) begin
      step_b(2'b11, 8'd0, 1'b1, 1'b1);
      @(negedge clk);
      check($sformatf("fixed%0d grant", c), 256'(bus_b.grant), 256'((c % 2 == 1) ? 2'b01 : 2'b00));
      if (c % 2 == 1)
        check($sformatf("fixed%0d oreq", c), 256'(bus_b.oreq), 256'(make_req(0, 1'b1, 8'd0)));
    end

    // 256-beat burst: beat counter saturation still matches len=255.
    step_b(2'b10, 8'd255, 1'b0, 1'b0);
    for (int b = 0; b < 256; b++) step_b(2'b10, 8'd255, 1'b1, (b == 255));
    @(negedge clk);
    check("long last grant", 256'(bus_b.grant), 256'(2'b10));
    step_b(2'b00, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("long after grant", 256'(bus_b.grant), 256'(0));
    check("long after len_err", 256'(bus_b.len_err), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
